// File: rtl/full_adder_s.sv
// One-bit full adder built from two half-adder stages, with an optional
// registered copy of the result and a valid flag that tracks reset release.
module full_adder_s #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic Cin,
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Cout,
  output logic Sum_r,
  output logic Cout_r,
  output logic Valid_r
);

  logic p, g, c2;

  // stage 1: half adder on the addends
  assign p    = A ^ B;
  assign g    = A & B;
  // stage 2: half adder folding in the carry
  assign Sum  = p ^ Cin;
  assign c2   = p & Cin;
  assign Cout = g | c2;

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          Sum_r   <= 1'b0;
          Cout_r  <= 1'b0;
          Valid_r <= 1'b0;
        end else begin
          Sum_r   <= Sum;
          Cout_r  <= Cout;
          Valid_r <= 1'b1;
        end
      end
    end else begin : g_noreg
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign Sum_r   = 1'b0;
      assign Cout_r  = 1'b0;
      assign Valid_r = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder_s.sv
// Directed checks of the full adder: truth table, registered path, async
// reset, one-cycle latency, and the unregistered build.
module tb_full_adder_s;

  logic clk, rst, Cin, A, B;
  logic sum1, cout1, sum_r1, cout_r1, valid_r1;
  logic sum0, cout0, sum_r0, cout_r0, valid_r0;

  int checks = 0;
  int errors = 0;

  full_adder_s #(.REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst(rst), .Cin(Cin), .A(A), .B(B),
    .Sum(sum1), .Cout(cout1), .Sum_r(sum_r1), .Cout_r(cout_r1), .Valid_r(valid_r1)
  );

  full_adder_s #(.REG_OUT(1'b0)) u_noreg (
    .clk(clk), .rst(rst), .Cin(Cin), .A(A), .B(B),
    .Sum(sum0), .Cout(cout0), .Sum_r(sum_r0), .Cout_r(cout_r0), .Valid_r(valid_r0)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  // one full clock period; returns with clk low, well away from the edge
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  // hand-computed {Cout,Sum} for {Cin,A,B} = 0..7
  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    logic exp_sum;
    logic [2:0] v;
    clk = 1'b0; rst = 1'b1; Cin = 1'b0; A = 1'b0; B = 1'b0;
    #3;
    chk("reset_regs", {1'b0, sum_r1, cout_r1, valid_r1}, 4'b0000);
    chk("reset_regs_noreg", {1'b0, sum_r0, cout_r0, valid_r0}, 4'b0000);

    // truth table with the clock idle
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {Cin, A, B} = v;
      #50;
      chk($sformatf("tt_%0d", i), {2'b00, cout1, sum1}, {2'b00, tt[i]});
    end

    // registered path after reset release
    {Cin, A, B} = 3'b011;
    rst = 1'b0;
    #2;
    chk("valid_before_edge", {3'b000, valid_r1}, 4'b0000);
    tick();
    chk("reg_path_11", {1'b0, sum_r1, cout_r1, valid_r1}, 4'b0011);

    // async reset between edges while inputs are 111
    {Cin, A, B} = 3'b111;
    tick();
    chk("reg_111", {1'b0, sum_r1, cout_r1, valid_r1}, 4'b0111);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_regs", {1'b0, sum_r1, cout_r1, valid_r1}, 4'b0000);
    chk("async_rst_comb", {2'b00, cout1, sum1}, 4'b0011);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_hold", {1'b0, sum_r1, cout_r1, valid_r1}, 4'b0000);
    tick();
    chk("post_rst_load", {1'b0, sum_r1, cout_r1, valid_r1}, 4'b0111);

    // latency: A toggles each cycle, Sum_r lags Sum by one edge
    {Cin, A, B} = 3'b000;
    for (int i = 0; i < 6; i++) begin
      exp_sum = A;
      tick();
      chk($sformatf("latency_%0d", i), {2'b00, sum_r1, valid_r1}, {2'b00, exp_sum, 1'b1});
      A = ~A;
      #1;
    end

    // unregistered build: clock running, registered outputs stay 0
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {Cin, A, B} = v;
      tick();
      chk($sformatf("noreg_regs_%0d", i), {1'b0, sum_r0, cout_r0, valid_r0}, 4'b0000);
      chk($sformatf("noreg_comb_%0d", i), {2'b00, cout0, sum0}, {2'b00, tt[i]});
      chk($sformatf("reg_cout_r_%0d", i), {2'b00, cout_r1, sum_r1}, {2'b00, tt[i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder_s.md
FULL_ADDER_S -- requirements
Module: full_adder_s

Interface
REQ-001 Parameter: REG_OUT, default 1, meaning 1 = registered outputs Sum_r/Cout_r/Valid_r active, 0 = those outputs tied 0.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-003 and REQ-004.
REQ-003 clk  input  1  rising-edge clock for the registered output stage.
REQ-004 rst  input  1  asynchronous, active-high reset of all registers.
REQ-005 Cin  input  1  carry-in bit.
REQ-006 A  input  1  addend bit A.
REQ-007 B  input  1  addend bit B.
REQ-008 Sum  output  1  combinational sum bit.
REQ-009 Cout  output  1  combinational carry-out bit.
REQ-010 Sum_r  output  1  Sum registered on clk.
REQ-011 Cout_r  output  1  Cout registered on clk.
REQ-012 Valid_r  output  1  high when Sum_r/Cout_r hold a sample taken after reset release.

Function
REQ-013 Sum SHALL equal A XOR B XOR Cin, purely combinational, with no dependence on clk or rst.
REQ-014 Cout SHALL equal (A AND B) OR (Cin AND (A XOR B)), purely combinational, with no dependence on clk or rst.
REQ-015 {Cout,Sum} SHALL equal the 2-bit arithmetic sum A+B+Cin for all 8 input combinations; the result range is 0..3 with no overflow.
REQ-016 Sum and Cout SHALL be built structurally from two half-adder stages (stage 1: A,B -> p=A^B, g=A&B; stage 2: p,Cin -> Sum=p^Cin, c2=p&Cin) and one OR gate (Cout=g|c2).
REQ-017 Sum and Cout SHALL settle within the same simulation time step as any input change and SHALL contain no latches.
REQ-018 With REG_OUT=1, on each rising clk edge with rst low, Sum_r SHALL capture Sum and Cout_r SHALL capture Cout, giving 1-cycle latency.
REQ-019 With REG_OUT=1, Valid_r SHALL be set to 1 on the first rising clk edge after rst deasserts and SHALL remain 1 until the next reset.
REQ-020 With REG_OUT=0, Sum_r, Cout_r and Valid_r SHALL be constant 0 and no flops SHALL be inferred.
REQ-021 The block SHALL have no handshake and no enable; the register stage samples on every clock edge.
REQ-022 An input change coincident with a clk edge SHALL be captured with its pre-edge value, following normal flop semantics.

Reset
REQ-023 When rst is asserted, Sum_r, Cout_r and Valid_r SHALL go to 0 immediately, without waiting for clk.
REQ-024 When rst is asserted mid-operation, the registered outputs SHALL clear at once, while Sum and Cout SHALL continue to follow the inputs.
REQ-025 When rst is deasserted, the first rising clk edge SHALL load the current Sum/Cout and set Valid_r.
REQ-026 An X or undriven value on clk while rst is high SHALL NOT change any register.

Verification
REQ-027 Exhaustive truth table: with clk idle, apply {Cin,A,B} = 000, 001, 010, 011, 100, 101, 110, 111, 50 time units apart; {Cout,Sum} SHALL equal 00, 01, 01, 10, 01, 10, 10, 11 respectively.
REQ-028 Registered path: reset released, clock running, A=1, B=1, Cin=0; after one rising edge, Sum_r=0, Cout_r=1 and Valid_r=1.
REQ-029 Asynchronous reset: with Sum_r=1, Cout_r=1 and Valid_r=1, pulse rst between clock edges; all three outputs SHALL go to 0 immediately while Sum=1 and Cout=1 remain driven from inputs 111.
REQ-030 Latency: toggle A on every clock edge with B=0 and Cin=0; Sum_r SHALL equal the value of Sum from exactly one cycle earlier.
REQ-031 REG_OUT=0 build: drive all 8 input combinations with the clock running; Sum_r, Cout_r and Valid_r SHALL stay 0, and Sum/Cout SHALL match REQ-027.
